// File: rtl/store_serializer.sv
// store_serializer: writes a latched 8/16/24-bit result onto an 8-bit memory
// bus as a sequence of byte writes. The most-significant active byte goes first,
// to the lowest address. All outputs are registered.
module store_serializer #(
  parameter int AW = 24
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [23:0]   data,
  input  logic [AW-1:0] addr,
  input  logic [1:0]    RWDTH,
  input  logic          RDY,
  output logic [AW-1:0] AB,
  output logic [7:0]    DO,
  output logic          WE,
  output logic          busy,
  output logic          done
);

  // state | meaning
  // IDLE  | no store pending; AB/DO keep their last values
  // W2    | bus write of byte [23:16] (24-bit stores only)
  // W1    | bus write of byte [15:8]
  // W0    | bus write of byte [7:0], the last byte of every store
  // FIN   | one-cycle done pulse; a new start is accepted here
  typedef enum logic [2:0] {IDLE, W2, W1, W0, FIN} state_t;

  localparam logic [AW-1:0] ADDR_STEP = AW'(1);

  state_t      state;
  logic [15:0] low_bytes;  // only the bytes that follow the first write are kept

  // Store sequencer. The width is decoded once at start into the entry state;
  // after that the remaining bytes come from low_bytes, so RWDTH, data and addr
  // may change freely while a store is in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      low_bytes <= '0;
      AB        <= '0;
      DO        <= '0;
      WE        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          done <= 1'b0;
          if (start) begin
            low_bytes <= data[15:0];
            AB        <= addr;
            WE        <= 1'b1;
            busy      <= 1'b1;
            case (RWDTH)
              2'b10: begin
                state <= W2;
                DO    <= data[23:16];
              end
              2'b01: begin
                state <= W1;
                DO    <= data[15:8];
              end
              default: begin
                state <= W0;
                DO    <= data[7:0];
              end
            endcase
          end else begin
            state <= IDLE;
          end
        end
        W2: begin
          if (RDY) begin
            AB    <= AB + ADDR_STEP;
            DO    <= low_bytes[15:8];
            state <= W1;
          end
        end
        W1: begin
          if (RDY) begin
            AB    <= AB + ADDR_STEP;
            DO    <= low_bytes[7:0];
            state <= W0;
          end
        end
        W0: begin
          // AB and DO hold on the final transfer so the bus is quiet in FIN.
          if (RDY) begin
            WE    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        default: begin
          state <= IDLE;
          WE    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_serializer.sv
// Directed bench for store_serializer: each bus cycle is checked against
// hand-computed values, and every accepted byte write is logged for later checks.
module tb_store_serializer;

  localparam int AW = 24;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [23:0]   data;
  logic [AW-1:0] addr;
  logic [1:0]    RWDTH;
  logic          RDY;
  logic [AW-1:0] AB;
  logic [7:0]    DO;
  logic          WE;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0] log_ab[$];
  logic [7:0]    log_do[$];

  store_serializer #(.AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .data(data), .addr(addr),
    .RWDTH(RWDTH), .RDY(RDY), .AB(AB), .DO(DO), .WE(WE), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // byte writes actually accepted by the bus
  always @(posedge clk) begin
    if (reset_n && WE && RDY) begin
      log_ab.push_back(AB);
      log_do.push_back(DO);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus(input string tag, input logic [AW-1:0] exp_ab, input logic [7:0] exp_do,
                           input logic exp_we, input logic exp_busy, input logic exp_done);
    check({tag, ".AB"}, 32'(AB), 32'(exp_ab));
    check({tag, ".DO"}, 32'(DO), 32'(exp_do));
    check({tag, ".WE"}, 32'(WE), 32'(exp_we));
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    check({tag, ".done"}, 32'(done), 32'(exp_done));
  endtask

  task automatic begin_store(input logic [23:0] d, input logic [AW-1:0] a, input logic [1:0] w);
    data  = d;
    addr  = a;
    RWDTH = w;
    start = 1'b1;
  endtask

  initial begin
    int base;
    int n77;
    reset_n = 1'b0;
    start   = 1'b0;
    data    = '0;
    addr    = '0;
    RWDTH   = 2'b00;
    RDY     = 1'b1;
    #3;
    check_bus("reset", 24'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_bus("idle", 24'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    // 8-bit store
    base = log_ab.size();
    begin_store(24'h1234A5, 24'h000200, 2'b00);
    tick();
    start = 1'b0;
    check_bus("r08.w0", 24'h000200, 8'hA5, 1'b1, 1'b1, 1'b0);
    tick();
    check_bus("r08.fin", 24'h000200, 8'hA5, 1'b0, 1'b0, 1'b1);
    tick();
    check_bus("r08.idle", 24'h000200, 8'hA5, 1'b0, 1'b0, 1'b0);
    check("r08.nwrites", 32'(log_ab.size() - base), 32'd1);

    // 24-bit store, RDY high throughout
    base = log_ab.size();
    begin_store(24'hC0FFEE, 24'h001000, 2'b10);
    tick();
    start = 1'b0;
    check_bus("r24.w2", 24'h001000, 8'hC0, 1'b1, 1'b1, 1'b0);
    tick();
    check_bus("r24.w1", 24'h001001, 8'hFF, 1'b1, 1'b1, 1'b0);
    tick();
    check_bus("r24.w0", 24'h001002, 8'hEE, 1'b1, 1'b1, 1'b0);
    tick();
    check_bus("r24.fin", 24'h001002, 8'hEE, 1'b0, 1'b0, 1'b1);
    tick();
    check("r24.done_clear", 32'(done), 32'd0);
    check("r24.nwrites", 32'(log_ab.size() - base), 32'd3);

    // 16-bit store across the address wrap, first byte stalled three cycles
    base = log_ab.size();
    begin_store(24'h00BEEF, 24'hFFFFFF, 2'b01);
    tick();
    start = 1'b0;
    RDY   = 1'b0;
    check_bus("wrap.w1", 24'hFFFFFF, 8'hBE, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bus($sformatf("wrap.stall%0d", i), 24'hFFFFFF, 8'hBE, 1'b1, 1'b1, 1'b0);
    end
    RDY = 1'b1;
    tick();
    check_bus("wrap.w0", 24'h000000, 8'hEF, 1'b1, 1'b1, 1'b0);
    tick();
    check_bus("wrap.fin", 24'h000000, 8'hEF, 1'b0, 1'b0, 1'b1);
    tick();
    check("wrap.done_once", 32'(done), 32'd0);
    check("wrap.nwrites", 32'(log_ab.size() - base), 32'd2);
    if (log_ab.size() - base == 2) begin
      check("wrap.log0", {log_do[base], log_ab[base]}, {8'hBE, 24'hFFFFFF});
      check("wrap.log1", {log_do[base+1], log_ab[base+1]}, {8'hEF, 24'h000000});
    end

    // start while busy must be ignored
    base = log_ab.size();
    begin_store(24'h112233, 24'h000300, 2'b10);
    tick();
    data  = 24'h777777;
    addr  = 24'h000900;
    RWDTH = 2'b00;
    check_bus("ign.w2", 24'h000300, 8'h11, 1'b1, 1'b1, 1'b0);
    tick();
    check_bus("ign.w1", 24'h000301, 8'h22, 1'b1, 1'b1, 1'b0);
    tick();
    check_bus("ign.w0", 24'h000302, 8'h33, 1'b1, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    check_bus("ign.fin", 24'h000302, 8'h33, 1'b0, 1'b0, 1'b1);
    tick();
    check_bus("ign.idle", 24'h000302, 8'h33, 1'b0, 1'b0, 1'b0);
    n77 = 0;
    for (int i = base; i < log_do.size(); i++)
      if (log_do[i] == 8'h77) n77++;
    check("ign.no77", 32'(n77), 32'd0);
    check("ign.nwrites", 32'(log_ab.size() - base), 32'd3);

    // back-to-back: start held high through FIN
    begin_store(24'h0000AA, 24'h000400, 2'b00);
    tick();
    data = 24'h0000BB;
    addr = 24'h000500;
    check_bus("b2b.first", 24'h000400, 8'hAA, 1'b1, 1'b1, 1'b0);
    tick();
    check_bus("b2b.fin1", 24'h000400, 8'hAA, 1'b0, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    check_bus("b2b.second", 24'h000500, 8'hBB, 1'b1, 1'b1, 1'b0);
    tick();
    check_bus("b2b.fin2", 24'h000500, 8'hBB, 1'b0, 1'b0, 1'b1);
    tick();

    // asynchronous reset in the middle of a 24-bit store
    begin_store(24'hABCDEF, 24'h002000, 2'b10);
    tick();
    start = 1'b0;
    tick();
    check_bus("rst.w1", 24'h002001, 8'hCD, 1'b1, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_bus("rst.async", 24'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    base = log_ab.size();
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst.quiet%0d", i), 32'(WE), 32'd0);
    end
    check("rst.nwrites", 32'(log_ab.size() - base), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/store_serializer.md
Name: store_serializer

Overview:
- Write-side counterpart of the multi-byte operand path: the CPU loads 8/16/24-bit operands as a byte sequence, and this block performs the matching store.
- Accepts one 24-bit result, a target address and a register width, then drives 1, 2 or 3 sequential byte writes onto the 8-bit data bus.
- Sits between the ALU/register-file output and the external memory bus, under control of the instruction FSM.

Parameters:
- AW, 24, address bus width; the address counter wraps modulo 2^AW.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a store; sampled only when busy=0.
- data  input  24  value to store; the active bytes are selected by RWDTH.
- addr  input  AW  address of the first byte written.
- RWDTH  input  2  width code from define.i: R_08=2'b00, R_16=2'b01, R_24=2'b10; 2'b11 is treated as R_08.
- RDY  input  1  bus ready; when low, the current write is held.
- AB  output  AW  bus address.
- DO  output  8  bus write data.
- WE  output  1  write enable.
- busy  output  1  a store is in progress.
- done  output  1  one-cycle pulse after the final byte is written.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, AB=0, DO=0, WE=0, busy=0, done=0. Asserting reset mid-store aborts it immediately; no further writes occur after release.
- States: IDLE, W2 (byte [23:16]), W1 (byte [15:8]), W0 (byte [7:0]), FIN.
- Start:
  - In IDLE or FIN, start=1 at a rising edge latches data, addr and width.
  - Next state is W2 for R_24, W1 for R_16, W0 for R_08 or 2'b11.
  - From the next cycle: WE=1, busy=1, AB=addr, DO=the MSB of the active width.
  - start while busy=1 is ignored, with no latching.
- Byte order matches the load path: the first bus cycle carries the most-significant active byte at addr, and each following byte goes to the next address.
  - R_16: [15:8]@A, then [7:0]@A+1.
  - R_24: [23:16]@A, [15:8]@A+1, [7:0]@A+2.
- Transfer rule: a byte is written on a rising edge where WE=1 and RDY=1.
  - On transfer, AB increments by 1 (wrapping 2^AW-1 to 0), DO loads the next lower byte, and state advances W2→W1→W0.
  - On transfer in W0: state=FIN, WE=0, busy=0, done=1 for exactly one cycle, AB and DO hold.
- Stall: while RDY=0 in W2/W1/W0, AB, DO, WE and state hold unchanged for any number of cycles.
- FIN returns to IDLE after one cycle, unless start=1, which begins a new store. Back-to-back stores therefore have exactly one non-WE cycle between them.
- Throughput: N bytes take N cycles plus 1 FIN cycle when RDY stays high. Latency from the start edge to the first WE cycle is 1 cycle.
- In IDLE: WE=0, done=0, and AB/DO hold their last values.
- Inactive upper bytes of data are ignored. The width latched at start governs the whole store; changes to RWDTH, data or addr while busy have no effect.
- No combinational path from any input to WE/AB/DO; all outputs are registered.

Test Plan:
- R_08 store: data=24'h1234A5, addr=24'h000200, RDY=1 → one WE cycle with AB=000200, DO=A5; done pulses the following cycle; busy high for exactly 1 cycle.
- R_24 store: data=24'hC0FFEE, addr=24'h001000, RDY=1 → consecutive writes C0@001000, FF@001001, EE@001002; done the following cycle; no gaps.
- Wrap and stalls: R_16, data=24'h00BEEF, addr=24'hFFFFFF, RDY low 3 cycles during the first byte → BE@FFFFFF held 4 cycles, then EF@000000; done once.
- Ignored start: start=1 while busy (second data=24'h777777) → first store completes unaltered; no 77 bytes written.
- Back-to-back: start held high through FIN → second store's first WE appears the cycle after done.
- Reset mid-op: reset_n=0 during W1 of an R_24 store → WE, busy and done drop asynchronously; AB=0, DO=0; no writes after release until a new start.
